// File: rtl/bcd_counter_n_if.sv
// Control and status bundle for bcd_counter_n; count/load_val carry one nibble
// per digit with digit 0 in the least significant nibble.
interface bcd_counter_n_if #(
  parameter int N_DIGITS = 4
);
  logic                    en_i;
  logic                    up_dn_i;
  logic                    load_i;
  logic [4*N_DIGITS-1:0]   load_val_i;
  logic                    clr_ovf_i;
  logic [4*N_DIGITS-1:0]   count_o;
  logic                    tc_o;
  logic                    ovf_o;
  logic                    load_err_o;

  modport master (
    output en_i, up_dn_i, load_i, load_val_i, clr_ovf_i,
    input  count_o, tc_o, ovf_o, load_err_o
  );

  modport slave (
    input  en_i, up_dn_i, load_i, load_val_i, clr_ovf_i,
    output count_o, tc_o, ovf_o, load_err_o
  );
endinterface

// File: rtl/bcd_counter_n.sv
// Cascaded modulo counter: N digits, per-digit radix (top digit may differ),
// up/down, parallel load with range check, terminal count and sticky overflow.
module bcd_counter_n #(
  parameter int N_DIGITS = 4,
  parameter int MOD      = 10,
  parameter int TOP_MOD  = 10
) (
  input  logic           clk,
  input  logic           rst,
  bcd_counter_n_if.slave bus
);
  logic [N_DIGITS-1:0][3:0] count_q;
  logic [N_DIGITS-1:0][3:0] count_d;
  logic [N_DIGITS-1:0]      at_b;
  logic [N_DIGITS-1:0]      bad_nib;
  logic                     ovf_q;
  logic                     ovf_d;
  logic                     load_err_q;
  logic                     load_err_d;
  logic                     wrap;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    localparam logic [3:0] LIM = 4'((i == N_DIGITS - 1) ? TOP_MOD - 1 : MOD - 1);
    // Bits below digit i; the step enable is the AND of their boundary flags.
    localparam logic [N_DIGITS-1:0] LOWER = {N_DIGITS{1'b1}} >> (N_DIGITS - i);

    logic [3:0] nib;
    logic [3:0] up_v;
    logic [3:0] dn_v;
    logic [3:0] step_v;
    logic       ripple;

    assign nib        = bus.load_val_i[4*i +: 4];
    assign bad_nib[i] = (nib > LIM);
    assign at_b[i]    = bus.up_dn_i ? (count_q[i] == LIM) : (count_q[i] == 4'd0);
    assign ripple     = &(at_b | ~LOWER);
    assign up_v       = (count_q[i] == LIM)  ? 4'd0 : count_q[i] + 4'd1;
    assign dn_v       = (count_q[i] == 4'd0) ? LIM  : count_q[i] - 4'd1;
    assign step_v     = bus.up_dn_i ? up_v : dn_v;
    assign count_d[i] = bus.load_i              ? (bad_nib[i] ? 4'd0 : nib) :
                        (bus.en_i && ripple)    ? step_v :
                                                  count_q[i];
  end

  assign wrap       = bus.en_i & ~bus.load_i & (&at_b);
  assign ovf_d      = wrap | (ovf_q & ~bus.clr_ovf_i);
  assign load_err_d = bus.load_i & (|bad_nib);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.count_o    = count_q;
  assign bus.tc_o       = wrap;
  assign bus.ovf_o      = ovf_q;
  assign bus.load_err_o = load_err_q;
endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: directed vector table on a 4-digit decade counter,
// hand sequences for reset and mixed radix, then randomized traffic vs a value model.
module tb_bcd_counter_n;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_counter_n_if #(.N_DIGITS(4)) ifa ();
  bcd_counter_n_if #(.N_DIGITS(3)) ifb ();

  bcd_counter_n #(.N_DIGITS(4), .MOD(10), .TOP_MOD(10)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  bcd_counter_n #(.N_DIGITS(3), .MOD(10), .TOP_MOD(6))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic ld; logic [15:0] val; logic en; logic up; logic clr;
    logic tc; logic [15:0] cnt; logic ovf; logic lerr;
  } vec_t;
  vec_t tbl[$];

  localparam int ND[2] = '{4, 3};
  localparam int MD[2] = '{10, 10};
  localparam int TM[2] = '{10, 6};

  // Model keeps the count as a plain integer in [0, total).
  int   mv[2];
  logic movf[2];
  logic mlerr[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lim(input int k, input int i);
    return (i == ND[k] - 1) ? TM[k] - 1 : MD[k] - 1;
  endfunction

  function automatic int total(input int k);
    int t = TM[k];
    for (int i = 0; i < ND[k] - 1; i++) t *= MD[k];
    return t;
  endfunction

  function automatic logic [15:0] to_nib(input int k, input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < ND[k]; i++) begin
      if (i == ND[k] - 1) r[4*i +: 4] = 4'(x);
      else begin
        r[4*i +: 4] = 4'(x % MD[k]);
        x = x / MD[k];
      end
    end
    return r;
  endfunction

  task automatic decode(input int k, input logic [15:0] lv, output int v, output logic err);
    int w = 1;
    v = 0; err = 1'b0;
    for (int i = 0; i < ND[k]; i++) begin
      int d = int'(lv[4*i +: 4]);
      if (d > lim(k, i)) begin d = 0; err = 1'b1; end
      v += d * w;
      w *= MD[k];
    end
  endtask

  function automatic logic exp_tc(input int k, input logic ld, input logic en, input logic up);
    return en & ~ld & (up ? (mv[k] == total(k) - 1) : (mv[k] == 0));
  endfunction

  task automatic model_step(input int k, input logic ld, input logic [15:0] lv,
                            input logic en, input logic up, input logic clr);
    logic w = 1'b0;
    if (ld) begin
      int v; logic e;
      decode(k, lv, v, e);
      mv[k] = v; mlerr[k] = e;
    end else begin
      mlerr[k] = 1'b0;
      if (en) begin
        w = exp_tc(k, ld, en, up);
        if (up) mv[k] = w ? 0 : mv[k] + 1;
        else    mv[k] = w ? total(k) - 1 : mv[k] - 1;
      end
    end
    movf[k] = w | (movf[k] & ~clr);
  endtask

  task automatic drive_a(input logic ld, input logic [15:0] lv, input logic en,
                         input logic up, input logic clr);
    ifa.load_i = ld; ifa.load_val_i = lv; ifa.en_i = en; ifa.up_dn_i = up; ifa.clr_ovf_i = clr;
  endtask

  task automatic drive_b(input logic ld, input logic [15:0] lv, input logic en,
                         input logic up, input logic clr);
    ifb.load_i = ld; ifb.load_val_i = lv[11:0]; ifb.en_i = en; ifb.up_dn_i = up; ifb.clr_ovf_i = clr;
  endtask

  function automatic vec_t mk(input logic ld, input logic [15:0] val, input logic en,
                              input logic up, input logic clr, input logic tc,
                              input logic [15:0] cnt, input logic ovf, input logic lerr);
    vec_t v;
    v.ld = ld; v.val = val; v.en = en; v.up = up; v.clr = clr;
    v.tc = tc; v.cnt = cnt; v.ovf = ovf; v.lerr = lerr;
    return v;
  endfunction

  initial begin
    //             ld  val       en up clr  tc cnt       ovf lerr
    tbl.push_back(mk(1, 16'h0008, 1, 1, 0,  0, 16'h0008, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 0,  0, 16'h0009, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 0,  0, 16'h0010, 0, 0));
    tbl.push_back(mk(1, 16'h0099, 0, 1, 0,  0, 16'h0099, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 0,  0, 16'h0100, 0, 0));
    tbl.push_back(mk(1, 16'h0999, 0, 1, 0,  0, 16'h0999, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 0,  0, 16'h1000, 0, 0));
    tbl.push_back(mk(1, 16'h9998, 1, 1, 0,  0, 16'h9998, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 0,  0, 16'h9999, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 0,  1, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0,  0, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 1,  0, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 16'h9999, 0, 1, 0,  0, 16'h9999, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 1,  1, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 1,  0, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 16'h0001, 0, 0, 0,  0, 16'h0001, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  1, 16'h9999, 1, 0));
    tbl.push_back(mk(1, 16'h1000, 0, 0, 1,  0, 16'h1000, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  0, 16'h0999, 0, 0));
    tbl.push_back(mk(1, 16'h1234, 1, 1, 0,  0, 16'h1234, 0, 0));
    tbl.push_back(mk(1, 16'h12A4, 0, 1, 0,  0, 16'h1204, 0, 1));
    tbl.push_back(mk(1, 16'h5678, 0, 1, 0,  0, 16'h5678, 0, 0));
    tbl.push_back(mk(1, 16'hF0F0, 0, 1, 0,  0, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0,  0, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 16'h0420, 0, 1, 0,  0, 16'h0420, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 16'h0000, 0, i[0], 0, 0, 16'h0420, 0, 0));
    tbl.push_back(mk(1, 16'h0005, 0, 1, 0,  0, 16'h0005, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 0,  0, 16'h0006, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  0, 16'h0005, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 0,  0, 16'h0006, 0, 0));
    tbl.push_back(mk(1, 16'h9999, 0, 1, 0,  0, 16'h9999, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 1, 1, 0,  0, 16'h0000, 0, 0));

    rst = 1'b1;
    drive_a(0, 16'h0, 0, 1, 0);
    drive_b(0, 16'h0, 0, 1, 0);
    #12;
    chk("reset_count_a", 32'(ifa.count_o), 32'h0);
    chk("reset_ovf_a", 32'(ifa.ovf_o), 32'h0);
    chk("reset_lerr_a", 32'(ifa.load_err_o), 32'h0);
    chk("reset_count_b", 32'(ifb.count_o), 32'h0);
    @(negedge clk) rst = 1'b0;

    foreach (tbl[n]) begin
      drive_a(tbl[n].ld, tbl[n].val, tbl[n].en, tbl[n].up, tbl[n].clr);
      #1;
      chk($sformatf("vec%0d_tc", n), 32'(ifa.tc_o), 32'(tbl[n].tc));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", n), 32'(ifa.count_o), 32'(tbl[n].cnt));
      chk($sformatf("vec%0d_ovf", n), 32'(ifa.ovf_o), 32'(tbl[n].ovf));
      chk($sformatf("vec%0d_lerr", n), 32'(ifa.load_err_o), 32'(tbl[n].lerr));
    end

    // Asynchronous reset mid-count with ovf set beforehand.
    drive_a(1, 16'h9999, 0, 1, 0); @(posedge clk); #1;
    drive_a(0, 16'h0000, 1, 1, 0); @(posedge clk); #1;
    drive_a(1, 16'h0347, 0, 1, 0); @(posedge clk); #1;
    chk("pre_rst_count", 32'(ifa.count_o), 32'h0347);
    chk("pre_rst_ovf", 32'(ifa.ovf_o), 32'h1);
    drive_a(0, 16'h0000, 1, 1, 0);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(ifa.count_o), 32'h0);
    chk("async_rst_ovf", 32'(ifa.ovf_o), 32'h0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("resume_count", 32'(ifa.count_o), 32'h0001);

    // Mixed radix: 3 digits, top digit modulo 6.
    drive_b(1, 16'h0599, 0, 1, 0);
    @(posedge clk); #1;
    chk("mix_load", 32'(ifb.count_o), 32'h599);
    drive_b(0, 16'h0, 1, 1, 0);
    #1 chk("mix_up_tc", 32'(ifb.tc_o), 32'h1);
    @(posedge clk); #1;
    chk("mix_up_wrap", 32'(ifb.count_o), 32'h000);
    chk("mix_up_ovf", 32'(ifb.ovf_o), 32'h1);
    drive_b(0, 16'h0, 1, 0, 1);
    #1 chk("mix_dn_tc", 32'(ifb.tc_o), 32'h1);
    @(posedge clk); #1;
    chk("mix_dn_wrap", 32'(ifb.count_o), 32'h599);
    chk("mix_dn_ovf", 32'(ifb.ovf_o), 32'h1);

    // Randomized traffic on both instances against the integer model.
    drive_a(0, 16'h0, 0, 1, 0);
    drive_b(0, 16'h0, 0, 1, 0);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin mv[k] = 0; movf[k] = 1'b0; mlerr[k] = 1'b0; end

    for (int it = 0; it < 1500; it++) begin
      logic        r_ld[2], r_en[2], r_up[2], r_clr[2];
      logic [15:0] r_lv[2];
      for (int k = 0; k < 2; k++) begin
        r_ld[k]  = ($urandom_range(0, 15) == 0);
        r_en[k]  = ($urandom_range(0, 3) != 0);
        r_up[k]  = $urandom_range(0, 1) == 1;
        r_clr[k] = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 3))
          0:       r_lv[k] = 16'($urandom);
          1:       r_lv[k] = to_nib(k, total(k) - 1);
          2:       r_lv[k] = 16'h0;
          default: r_lv[k] = to_nib(k, int'($urandom_range(0, total(k) - 1)));
        endcase
      end
      drive_a(r_ld[0], r_lv[0], r_en[0], r_up[0], r_clr[0]);
      drive_b(r_ld[1], r_lv[1], r_en[1], r_up[1], r_clr[1]);
      #1;
      chk("rnd_tc_a", 32'(ifa.tc_o), 32'(exp_tc(0, r_ld[0], r_en[0], r_up[0])));
      chk("rnd_tc_b", 32'(ifb.tc_o), 32'(exp_tc(1, r_ld[1], r_en[1], r_up[1])));
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) model_step(k, r_ld[k], r_lv[k], r_en[k], r_up[k], r_clr[k]);
      chk("rnd_count_a", 32'(ifa.count_o), 32'(to_nib(0, mv[0])));
      chk("rnd_ovf_a", 32'(ifa.ovf_o), 32'(movf[0]));
      chk("rnd_lerr_a", 32'(ifa.load_err_o), 32'(mlerr[0]));
      chk("rnd_count_b", 32'(ifb.count_o), 32'(to_nib(1, mv[1]) & 16'h0FFF));
      chk("rnd_ovf_b", 32'(ifb.ovf_o), 32'(movf[1]));
      chk("rnd_lerr_b", 32'(ifb.load_err_o), 32'(mlerr[1]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
